credit_link_tx: RTL and testbench
=================================

Name: credit_link_tx

Overview:
- Transmit side of a router-to-router link feeding the downstream router's input FIFO (default depth 3).
- Uses credit-based flow control. Holds one credit per free downstream FIFO slot, spends one per flit sent, and regains one per credit pulse returned when the downstream FIFO pops.
- Registers the link outputs so the downstream FIFO's push/din come straight from flops.
- Sits between the crossbar/output arbiter and the physical link of each output port.

Parameters:
- DEPTH, 3, depth of the downstream FIFO; initial and maximum credit count.
- DATA_WIDTH, 32, flit width in bits.
- CREDIT_BITS, $clog2(DEPTH+1), credit counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream flit available.
- in_data  input  DATA_WIDTH  upstream flit.
- in_ready  output  1  block accepts a flit this cycle.
- link_valid  output  1  drives downstream FIFO push.
- link_data  output  DATA_WIDTH  drives downstream FIFO din.
- credit_in  input  1  one-cycle pulse per downstream FIFO pop.
- credits  output  CREDIT_BITS  current credit count.
- credit_err  output  1  sticky credit-overflow error.

Behaviour:
- Reset (async assert, any time, including mid-transfer):
  - credits = DEPTH; link_valid = 0; link_data = 0; credit_err = 0; state = INIT.
  - Any in-flight flit is discarded. The downstream FIFO is reset by the same reset.
- FSM states: INIT, RUN, HALT.
  - INIT: lasts exactly one cycle after reset deasserts, then goes to RUN. in_ready = 0.
  - RUN: in_ready = (credits != 0). fire = in_valid & in_ready.
  - HALT: entered from RUN when credit_in = 1 while credits == DEPTH and no fire occurs that cycle (credit overflow). Sets credit_err = 1.
  - HALT is held until reset. In HALT: in_ready = 0, link_valid = 0, credits frozen.
- Transfer:
  - On fire: link_data <= in_data and link_valid <= 1 on the next edge. Latency is 1 cycle.
  - link_valid is high for exactly one cycle per fired flit. Back-to-back fires give back-to-back link_valid pulses.
  - Without fire: link_valid <= 0 and link_data holds its last value.
- Credit arithmetic, per edge in RUN:
  - fire & ~credit_in: credits - 1.
  - ~fire & credit_in: credits + 1.
  - fire & credit_in: unchanged.
  - neither: unchanged.
- credits never goes below 0; in_ready gating guarantees this.
- in_ready depends only on registered credits and state, never combinationally on credit_in or in_valid. A credit returned at count 0 is usable on the next cycle.
- fire & credit_in while credits == DEPTH is legal. The count stays at DEPTH and there is no error.
- in_valid asserted without in_ready: no transfer. Upstream must hold in_data stable until fire.
- credit_in during INIT is counted as overflow: set credit_err, enter HALT.

Optional Feature:
- Macro: CREDIT_LINK_TX_STATS_EN.
- Defined: adds outputs flit_count (32 bits, +1 per fire) and stall_count (32 bits, +1 per RUN cycle with in_valid & ~in_ready).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan (DEPTH=3, DATA_WIDTH=32):
- Reset, then in_valid held with in_data 0xA0, 0xA1, 0xA2, 0xA3, credit_in = 0:
  - in_ready = 0 in the INIT cycle.
  - Three fires; link_data 0xA0, 0xA1, 0xA2 on consecutive cycles, each 1 cycle after fire.
  - credits 3→2→1→0; in_ready = 0 afterwards; 0xA3 is held.
- From credits = 0 with 0xA3 pending, pulse credit_in once:
  - credits = 1 on the next cycle; in_ready = 1 that cycle; 0xA3 fires; credits back to 0; link_data = 0xA3 the following cycle.
- At credits = 1, fire together with credit_in:
  - credits stays 1; link_valid = 1 on the next cycle.
- At credits = 3, pulse credit_in with no fire:
  - credit_err = 1 and state HALT on the next cycle; in_ready = 0; link_valid stays 0 despite in_valid = 1; only reset clears it.
- Assert reset asynchronously while link_valid = 1:
  - link_valid = 0, link_data = 0, credits = 3 immediately, without waiting for a clock edge.
- With CREDIT_LINK_TX_STATS_EN, 5 flits offered and 2 credits returned mid-stream:
  - flit_count = 5; stall_count equals the number of RUN cycles with in_valid = 1 and credits = 0.

Source files
------------

// File: rtl/credit_link_tx.sv
// Credit-based link transmitter: forwards flits to the downstream FIFO while it holds credits; optional stats via CREDIT_LINK_TX_STATS_EN.
// Latency: 1 cycle from fire to link_valid/link_data, which come straight from flops.
// Backpressure: in_ready is low in INIT and HALT and when credits hit zero; it depends only on registered state.
module credit_link_tx #(
  parameter int DEPTH       = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int CREDIT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   link_valid,
  output logic [DATA_WIDTH-1:0]  link_data,
  input  logic                   credit_in,
  output logic [CREDIT_BITS-1:0] credits,
  output logic                   credit_err
`ifdef CREDIT_LINK_TX_STATS_EN
  ,
  output logic [31:0]            flit_count,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CREDIT_BITS-1:0] CRED_MAX = CREDIT_BITS'(DEPTH);
  localparam logic [CREDIT_BITS-1:0] CRED_ONE = CREDIT_BITS'(1);

  state_t                  state_q, state_d;
  logic [CREDIT_BITS-1:0]  credits_q, credits_d;
  logic                    link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0]   link_data_q, link_data_d;
  logic                    credit_err_q, credit_err_d;
  logic                    fire;
  logic                    overflow;

  // A flit moves only when upstream offers it and the output side is ready.
  assign fire = in_valid & in_ready;

  // A returned credit with nowhere to go: any credit during INIT, or one at a full count with no fire to absorb it.
  always_comb begin
    overflow = 1'b0;
    case (state_q)
      ST_INIT: overflow = credit_in;
      ST_RUN:  overflow = credit_in & ~fire & (credits_q == CRED_MAX);
      default: overflow = 1'b0;
    endcase
  end

  // FSM state register; reset returns to INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // FSM next state: INIT lasts one cycle, overflow traps in HALT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = overflow ? ST_HALT : ST_RUN;
      ST_RUN:  state_d = overflow ? ST_HALT : ST_RUN;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // FSM outputs: accept only while running with at least one credit in hand.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_RUN:  in_ready = (credits_q != '0);
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next values: credit accounting, one-cycle link pulse, sticky error.
  always_comb begin
    credits_d    = credits_q;
    link_valid_d = 1'b0;
    link_data_d  = link_data_q;
    credit_err_d = credit_err_q | overflow;
    if (state_q == ST_RUN && !overflow) begin
      if (fire && !credit_in)      credits_d = credits_q - CRED_ONE;
      else if (!fire && credit_in) credits_d = credits_q + CRED_ONE;
      link_valid_d = fire;
      if (fire) link_data_d = in_data;
    end
  end

  // Datapath registers; reset discards any in-flight flit and refills credits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q    <= CRED_MAX;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign credits    = credits_q;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign credit_err = credit_err_q;

`ifdef CREDIT_LINK_TX_STATS_EN
  logic [31:0] flit_count_q, flit_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Stats next values: flits sent, and running cycles where upstream waited on us.
  always_comb begin
    flit_count_d  = flit_count_q;
    stall_count_d = stall_count_q;
    if (fire) flit_count_d = flit_count_q + 32'd1;
    if (state_q == ST_RUN && in_valid && !in_ready) stall_count_d = stall_count_q + 32'd1;
  end

  // Stats registers, free-running modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      flit_count_q  <= flit_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign flit_count  = flit_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_credit_link_tx.sv
// Self-checking bench for credit_link_tx: directed steps followed by randomized traffic.
// Latency: expectations come from a cycle-level reference model of the credit rules.
// Backpressure: upstream holds data until fire; credits are returned only for flits outstanding.
module tb_credit_link_tx;
  localparam int DEPTH = 3;
  localparam int DW    = 32;
  localparam int CB    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic          credit_in;
  logic [CB-1:0] credits;
  logic          credit_err;
`ifdef CREDIT_LINK_TX_STATS_EN
  logic [31:0]   flit_count;
  logic [31:0]   stall_count;
`endif

  credit_link_tx #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .link_valid (link_valid),
    .link_data  (link_data),
    .credit_in  (credit_in),
    .credits    (credits),
    .credit_err (credit_err)
`ifdef CREDIT_LINK_TX_STATS_EN
    ,
    .flit_count (flit_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = just out of reset, 1 = running, 2 = halted.
  int          m_cred;
  int          m_phase;
  bit          m_lv;
  logic [31:0] m_ld;
  bit          m_err;
  int unsigned m_flits;
  int unsigned m_stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (m_phase == 1) && (m_cred > 0);
  endfunction

  task automatic model_reset();
    m_cred = DEPTH; m_phase = 0; m_lv = 0; m_ld = '0; m_err = 0;
    m_flits = 0; m_stalls = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".in_ready"},   32'(in_ready),   32'(model_ready()));
    check({ctx, ".credits"},    32'(credits),    32'(m_cred));
    check({ctx, ".link_valid"}, 32'(link_valid), 32'(m_lv));
    check({ctx, ".link_data"},  link_data,       m_ld);
    check({ctx, ".credit_err"}, 32'(credit_err), 32'(m_err));
`ifdef CREDIT_LINK_TX_STATS_EN
    check({ctx, ".flit_count"},  flit_count,  32'(m_flits));
    check({ctx, ".stall_count"}, stall_count, 32'(m_stalls));
`endif
  endtask

  // Called at a negedge: check present outputs, drive inputs, advance model, move to next negedge.
  task automatic step(input string ctx, input bit v, input logic [31:0] d, input bit c);
    bit rdy, fire;
    check_outputs(ctx);
    in_valid = v; in_data = d; credit_in = c;
    rdy  = model_ready();
    fire = v && rdy;
    if (m_phase == 0) begin
      m_lv = 0;
      if (c) begin m_phase = 2; m_err = 1; end
      else m_phase = 1;
    end else if (m_phase == 1) begin
      if (v && !rdy) m_stalls++;
      if (c && !fire && m_cred == DEPTH) begin
        m_phase = 2; m_err = 1; m_lv = 0;
      end else begin
        m_cred = m_cred + (c ? 1 : 0) - (fire ? 1 : 0);
        m_lv   = fire;
        if (fire) begin m_ld = d; m_flits++; end
      end
    end else begin
      m_lv = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; credit_in = 1'b0; in_data = '0;
    model_reset();
    #1;
    check_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] pend;
  bit          have;

  initial begin
    reset = 1'b1; in_valid = 1'b0; credit_in = 1'b0; in_data = '0;
    @(negedge clk);
    do_reset();

    // Fill the downstream FIFO: INIT cycle, three fires, then stall with 0xA3 held.
    step("init",   1, 32'hA0, 0);
    step("fire_a0",1, 32'hA0, 0);
    step("fire_a1",1, 32'hA1, 0);
    step("fire_a2",1, 32'hA2, 0);
    check("a2_on_link", link_data, 32'hA2);
    step("empty0", 1, 32'hA3, 0);
    check("empty_credits", 32'(credits), 32'd0);
    step("credit1",1, 32'hA3, 1);
    check("reg_credit_ready", 32'(in_ready), 32'd1);
    step("fire_a3",1, 32'hA3, 0);
    step("after_a3",0, 32'hA3, 0);
    check("a3_on_link", link_data, 32'hA3);

    // Fire together with a credit return at count 1: count holds.
    step("ret1",   0, 32'hA3, 1);
    step("both",   1, 32'hB0, 1);
    check("both_credits", 32'(credits), 32'd1);
    check("both_lv", 32'(link_valid), 32'd1);
    step("ret2",   0, 32'hB0, 1);
    step("ret3",   0, 32'hB0, 1);
    check("full_credits", 32'(credits), 32'd3);

    // Legal: fire plus credit at a full count, no error.
    step("full_both", 1, 32'hB1, 1);
    check("full_both_err", 32'(credit_err), 32'd0);

    // Overflow: credit at a full count with no fire traps in HALT.
    step("ovf",    0, 32'hB1, 1);
    check("ovf_err", 32'(credit_err), 32'd1);
    for (int i = 0; i < 4; i++) step("halt", 1, 32'hC0 + 32'(i), (i == 1));
    check("halt_lv", 32'(link_valid), 32'd0);

    // Reset clears HALT; a credit during INIT is an overflow.
    do_reset();
    step("init_ovf", 0, 32'h0, 1);
    step("init_halt",1, 32'hC5, 0);
    check("init_ovf_err", 32'(credit_err), 32'd1);

    // Asynchronous reset while a flit is on the link.
    do_reset();
    step("ar_init", 1, 32'hD0, 0);
    step("ar_fire", 1, 32'hD1, 0);
    check("ar_pre_lv", 32'(link_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("ar_lv",      32'(link_valid), 32'd0);
    check("ar_ld",      link_data,       32'd0);
    check("ar_credits", 32'(credits),    32'(DEPTH));
    in_valid = 1'b0; credit_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic: upstream holds data until it fires, credits returned only for outstanding flits.
    have = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, c, will_fire;
      v = ($urandom_range(0, 9) < 7);
      c = (m_cred < DEPTH) && ($urandom_range(0, 2) == 0);
      if (!have) begin pend = $urandom; have = 1; end
      will_fire = v && model_ready();
      step("rand", v, pend, c);
      if (will_fire) have = 0;
    end
    step("final", 0, pend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
